// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared state encoding and width / field helpers
// for the parametrised direct-mapped cache controller.
package cache_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_WB,
      S_FILL,
      S_RETRY,
      S_DONE
   } state_t;

   function automatic int boff_w(int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int woff_w(int words);
      return $clog2(words);
   endfunction

   function automatic int tag_w(int addr_w, int index_w,
                                int words, int data_w);
      return addr_w - index_w - woff_w(words) - boff_w(data_w);
   endfunction

   function automatic logic [63:0] field(logic [63:0] a,
                                         int lo, int w);
      return (a >> lo) & ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/cache_fill_tracker.sv
// cache_fill_tracker: follows accepted memory reads through the
// fixed read latency and counts returns written into the line.
module cache_fill_tracker #(
   parameter  int WORDS   = 4,
   parameter  int MEM_LAT = 2,
   localparam int WW      = $clog2(WORDS)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic [WW-1:0] push_word,
   output logic          out_valid,
   output logic [WW-1:0] out_word,
   output logic [WW:0]   done_cnt
);

   localparam logic [WW:0] ONE = 1;

   logic [MEM_LAT-1:0] vld;
   logic [WW-1:0]      wrd [MEM_LAT];

   // shift one stage per cycle; a read returns when it leaves the pipe
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         vld <= '0;
         for (int k = 0; k < MEM_LAT; k++) wrd[k] <= '0;
      end else begin
         vld[0] <= push;
         wrd[0] <= push_word;
         for (int k = 1; k < MEM_LAT; k++) begin
            vld[k] <= vld[k-1];
            wrd[k] <= wrd[k-1];
         end
      end
   end

   // number of returns already written into the cache
   always_ff @(posedge clk) begin
      if (rst || clr)     done_cnt <= '0;
      else if (out_valid) done_cnt <= done_cnt + ONE;
   end

   assign out_valid = vld[MEM_LAT-1];
   assign out_word  = wrd[MEM_LAT-1];

endmodule

// File: rtl/cache_ctrl_param.sv
// cache_ctrl_param: direct-mapped cache controller FSM with
// write-back, pipelined line fill, memory stall retry and errors.
module cache_ctrl_param
   import cache_ctrl_pkg::*;
#(
   parameter  int ADDR_W  = 16,
   parameter  int DATA_W  = 16,
   parameter  int INDEX_W = 8,
   parameter  int WORDS   = 4,
   parameter  int MEM_LAT = 2,
   localparam int BOFF_W  = boff_w(DATA_W),
   localparam int WOFF_W  = woff_w(WORDS),
   localparam int TAG_W   = tag_w(ADDR_W, INDEX_W, WORDS, DATA_W),
   localparam int OFF_W   = WOFF_W + BOFF_W
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  Addr,
   input  logic [DATA_W-1:0]  DataIn,
   input  logic               Rd,
   input  logic               Wr,
   input  logic               hit,
   input  logic               dirty,
   input  logic               valid,
   input  logic [TAG_W-1:0]   tag_out,
   input  logic [DATA_W-1:0]  DataOut_cache,
   input  logic [DATA_W-1:0]  DataOut_mem,
   input  logic               stall,
   output logic               enable_ct,
   output logic               cmp_ct,
   output logic               wr_cache,
   output logic               valid_in_ct,
   output logic [INDEX_W-1:0] index_cache,
   output logic [OFF_W-1:0]   offset_cache,
   output logic [TAG_W-1:0]   tag_cache,
   output logic [DATA_W-1:0]  DataIn_ct,
   output logic [ADDR_W-1:0]  Addr_mem,
   output logic [DATA_W-1:0]  DataIn_mem,
   output logic               wr_mem,
   output logic               rd_mem,
   output logic [DATA_W-1:0]  DataOut,
   output logic               Done,
   output logic               CacheHit,
   output logic               Stall_sys,
   output logic               err
);

   localparam int CNT_W = WOFF_W + 1;
   localparam int TAG_LO = OFF_W + INDEX_W;
   localparam logic [CNT_W-1:0] N_WORDS = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] ONE = 1;

   state_t              state;
   logic                op_wr;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [CNT_W-1:0]    cnt;
   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_idx;
   logic [OFF_W-1:0]    req_off;
   logic [WOFF_W-1:0]   word;
   logic [BOFF_W-1:0]   bz;
   logic                bad;
   logic                issue_ok;
   logic                fill_last;
   logic                trk_valid;
   logic [WOFF_W-1:0]   trk_word;
   logic [CNT_W-1:0]    trk_cnt;

   assign req_tag = TAG_W'(field(64'(addr_q), TAG_LO, TAG_W));
   assign req_idx = INDEX_W'(field(64'(addr_q), OFF_W, INDEX_W));
   assign req_off = OFF_W'(field(64'(addr_q), 0, OFF_W));
   assign word    = cnt[WOFF_W-1:0];
   assign bz      = '0;
   assign bad     = |Addr[BOFF_W-1:0];

   assign issue_ok  = (state == S_FILL) && (cnt < N_WORDS) && !stall;
   assign fill_last = trk_valid && (trk_cnt == LAST);
   assign Stall_sys = (state != S_IDLE);

   cache_fill_tracker #(
      .WORDS   (WORDS),
      .MEM_LAT (MEM_LAT)
   ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .clr       (state != S_FILL),
      .push      (issue_ok),
      .push_word (word),
      .out_valid (trk_valid),
      .out_word  (trk_word),
      .done_cnt  (trk_cnt)
   );

   // sequencing, request latch, counters and registered results
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         op_wr    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         cnt      <= '0;
         DataOut  <= '0;
         Done     <= 1'b0;
         CacheHit <= 1'b0;
         err      <= 1'b0;
      end else begin
         Done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               CacheHit <= 1'b0;
               if ((Rd && Wr) || ((Rd || Wr) && bad)) begin
                  err <= 1'b1;
               end else if (Rd ^ Wr) begin
                  addr_q <= Addr;
                  data_q <= DataIn;
                  op_wr  <= Wr;
                  state  <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               cnt <= '0;
               if (hit && valid) begin
                  if (!op_wr) DataOut <= DataOut_cache;
                  CacheHit <= 1'b1;
                  Done     <= 1'b1;
                  state    <= S_DONE;
               end else if (valid && dirty) begin
                  state <= S_WB;
               end else begin
                  state <= S_FILL;
               end
            end
            S_WB: begin
               if (!stall) begin
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= S_FILL;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
            end
            S_FILL: begin
               if (issue_ok)  cnt   <= cnt + ONE;
               if (fill_last) state <= S_RETRY;
            end
            S_RETRY: begin
               if (!op_wr) DataOut <= DataOut_cache;
               CacheHit <= 1'b0;
               Done     <= 1'b1;
               state    <= S_DONE;
            end
            S_DONE: begin
               CacheHit <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               err   <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // cache and memory strobes decoded from the current state
   always_comb begin
      enable_ct    = 1'b0;
      cmp_ct       = 1'b0;
      wr_cache     = 1'b0;
      valid_in_ct  = 1'b0;
      index_cache  = '0;
      offset_cache = '0;
      tag_cache    = '0;
      DataIn_ct    = '0;
      Addr_mem     = '0;
      DataIn_mem   = '0;
      wr_mem       = 1'b0;
      rd_mem       = 1'b0;
      case (state)
         S_COMPARE, S_RETRY: begin
            enable_ct    = 1'b1;
            cmp_ct       = 1'b1;
            wr_cache     = op_wr;
            index_cache  = req_idx;
            offset_cache = req_off;
            tag_cache    = req_tag;
            DataIn_ct    = data_q;
         end
         S_WB: begin
            enable_ct    = 1'b1;
            index_cache  = req_idx;
            offset_cache = {word, bz};
            tag_cache    = req_tag;
            wr_mem       = 1'b1;
            Addr_mem     = {tag_out, req_idx, word, bz};
            DataIn_mem   = DataOut_cache;
         end
         S_FILL: begin
            if (cnt < N_WORDS) begin
               rd_mem   = 1'b1;
               Addr_mem = {req_tag, req_idx, word, bz};
            end
            if (trk_valid) begin
               enable_ct    = 1'b1;
               wr_cache     = 1'b1;
               valid_in_ct  = 1'b1;
               index_cache  = req_idx;
               offset_cache = {trk_word, bz};
               tag_cache    = req_tag;
               DataIn_ct    = DataOut_mem;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl_param.sv
// tb_cache_ctrl_param: scoreboard bench for the cache controller,
// default geometry plus a WORDS=8 / MEM_LAT=4 instance.
module tb_cache_ctrl_param;

   typedef struct {
      int          cyc;
      logic [15:0] data;
      logic        ck;
      logic        hit;
   } done_e;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
   } mem_e;

   typedef struct {
      logic [3:0]  off;
      logic [15:0] data;
      logic [4:0]  tag;
   } fill_e;

   typedef struct {
      int          cyc;
      logic [2:0]  off;
      logic [15:0] data;
   } cwr_e;

   done_e done_q[$];
   mem_e  mem_q[$];
   fill_e fill_q[$];
   cwr_e  cwr_q[$];
   int    err_q[$];
   done_e done2_q[$];
   mem_e  mem2_q[$];
   fill_e fill2_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT 1: defaults ----------------
   logic        rst;
   logic [15:0] Addr, DataIn, DataOut_cache, DataOut_mem;
   logic        Rd, Wr, hit, dirty, valid, stall;
   logic [4:0]  tag_out;
   logic        enable_ct, cmp_ct, wr_cache, valid_in_ct;
   logic [7:0]  index_cache;
   logic [2:0]  offset_cache;
   logic [4:0]  tag_cache;
   logic [15:0] DataIn_ct, Addr_mem, DataIn_mem, DataOut;
   logic        wr_mem, rd_mem, Done, CacheHit, Stall_sys, err;
   logic [15:0] cbase;
   logic [15:0] mp [2];

   function automatic logic [15:0] mdata(logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   assign DataOut_cache = cbase + 16'(offset_cache);
   assign DataOut_mem   = mp[1];

   always @(posedge clk) begin
      mp[0] <= (rd_mem && !stall) ? mdata(Addr_mem) : 16'hDEAD;
      mp[1] <= mp[0];
   end

   cache_ctrl_param dut (
      .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn),
      .Rd(Rd), .Wr(Wr), .hit(hit), .dirty(dirty), .valid(valid),
      .tag_out(tag_out), .DataOut_cache(DataOut_cache),
      .DataOut_mem(DataOut_mem), .stall(stall),
      .enable_ct(enable_ct), .cmp_ct(cmp_ct), .wr_cache(wr_cache),
      .valid_in_ct(valid_in_ct), .index_cache(index_cache),
      .offset_cache(offset_cache), .tag_cache(tag_cache),
      .DataIn_ct(DataIn_ct), .Addr_mem(Addr_mem),
      .DataIn_mem(DataIn_mem), .wr_mem(wr_mem), .rd_mem(rd_mem),
      .DataOut(DataOut), .Done(Done), .CacheHit(CacheHit),
      .Stall_sys(Stall_sys), .err(err)
   );

   // ---------------- DUT 2: WORDS=8, MEM_LAT=4 ----------------
   logic        rst2;
   logic [15:0] Addr2, DataIn2, DataOut_cache2, DataOut_mem2;
   logic        Rd2, Wr2, hit2, dirty2, valid2, stall2;
   logic [3:0]  tag_out2;
   logic        enable_ct2, cmp_ct2, wr_cache2, valid_in_ct2;
   logic [7:0]  index_cache2;
   logic [3:0]  offset_cache2;
   logic [3:0]  tag_cache2;
   logic [15:0] DataIn_ct2, Addr_mem2, DataIn_mem2, DataOut2;
   logic        wr_mem2, rd_mem2, Done2, CacheHit2, Stall_sys2, err2;
   logic [15:0] mp2 [4];

   assign DataOut_cache2 = 16'h00C2;
   assign DataOut_mem2   = mp2[3];

   always @(posedge clk) begin
      mp2[0] <= (rd_mem2 && !stall2) ? mdata(Addr_mem2) : 16'hDEAD;
      mp2[1] <= mp2[0];
      mp2[2] <= mp2[1];
      mp2[3] <= mp2[2];
   end

   cache_ctrl_param #(.WORDS(8), .MEM_LAT(4)) dut2 (
      .clk(clk), .rst(rst2), .Addr(Addr2), .DataIn(DataIn2),
      .Rd(Rd2), .Wr(Wr2), .hit(hit2), .dirty(dirty2), .valid(valid2),
      .tag_out(tag_out2), .DataOut_cache(DataOut_cache2),
      .DataOut_mem(DataOut_mem2), .stall(stall2),
      .enable_ct(enable_ct2), .cmp_ct(cmp_ct2), .wr_cache(wr_cache2),
      .valid_in_ct(valid_in_ct2), .index_cache(index_cache2),
      .offset_cache(offset_cache2), .tag_cache(tag_cache2),
      .DataIn_ct(DataIn_ct2), .Addr_mem(Addr_mem2),
      .DataIn_mem(DataIn_mem2), .wr_mem(wr_mem2), .rd_mem(rd_mem2),
      .DataOut(DataOut2), .Done(Done2), .CacheHit(CacheHit2),
      .Stall_sys(Stall_sys2), .err(err2)
   );

   // ---------------- checking helpers ----------------
   task automatic chk(input string n, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  n, act, exp, cyc);
      end
   endtask

   task automatic unexp(input string n);
      n_vec++;
      n_err++;
      $display("FAIL %s: unexpected event at cycle %0d", n, cyc);
   endtask

   task automatic exp_done(input int c, input logic [15:0] d,
                           input logic ck, input logic h);
      done_e e;
      e.cyc = c; e.data = d; e.ck = ck; e.hit = h;
      done_q.push_back(e);
   endtask

   task automatic exp_mem(input logic w, input logic [15:0] a,
                          input logic [15:0] d);
      mem_e e;
      e.wr = w; e.addr = a; e.data = d;
      mem_q.push_back(e);
   endtask

   task automatic exp_fill(input logic [3:0] o, input logic [15:0] d,
                           input logic [4:0] t);
      fill_e e;
      e.off = o; e.data = d; e.tag = t;
      fill_q.push_back(e);
   endtask

   task automatic exp_cwr(input int c, input logic [2:0] o,
                          input logic [15:0] d);
      cwr_e e;
      e.cyc = c; e.off = o; e.data = d;
      cwr_q.push_back(e);
   endtask

   // ---------------- monitor, DUT 1 ----------------
   always @(negedge clk) begin
      if (Done) begin
         if (done_q.size() == 0) unexp("done");
         else begin
            done_e e;
            e = done_q.pop_front();
            chk("done_cyc", 128'(cyc), 128'(e.cyc));
            chk("cachehit", 128'(CacheHit), 128'(e.hit));
            if (e.ck) chk("dataout", 128'(DataOut), 128'(e.data));
         end
      end
      if ((rd_mem || wr_mem) && !stall) begin
         if (mem_q.size() == 0) unexp("mem_op");
         else begin
            mem_e e;
            e = mem_q.pop_front();
            chk("mem_wr", 128'(wr_mem), 128'(e.wr));
            chk("mem_addr", 128'(Addr_mem), 128'(e.addr));
            if (e.wr) chk("mem_wdata", 128'(DataIn_mem), 128'(e.data));
         end
      end
      if (wr_cache && !cmp_ct) begin
         if (fill_q.size() == 0) unexp("fill");
         else begin
            fill_e e;
            e = fill_q.pop_front();
            chk("fill_off", 128'(offset_cache), 128'(e.off));
            chk("fill_data", 128'(DataIn_ct), 128'(e.data));
            chk("fill_tag", 128'(tag_cache), 128'(e.tag));
            chk("fill_vin", 128'({enable_ct, valid_in_ct}), 128'(3));
         end
      end
      if (wr_cache && cmp_ct) begin
         if (cwr_q.size() == 0) unexp("cmp_write");
         else begin
            cwr_e e;
            e = cwr_q.pop_front();
            chk("cwr_cyc", 128'(cyc), 128'(e.cyc));
            chk("cwr_off", 128'(offset_cache), 128'(e.off));
            chk("cwr_data", 128'(DataIn_ct), 128'(e.data));
         end
      end
      if (err) begin
         if (err_q.size() == 0) unexp("err");
         else chk("err_cyc", 128'(cyc), 128'(err_q.pop_front()));
      end
   end

   // ---------------- monitor, DUT 2 ----------------
   always @(negedge clk) begin
      if (Done2) begin
         if (done2_q.size() == 0) unexp("done2");
         else begin
            done_e e;
            e = done2_q.pop_front();
            chk("done2_cyc", 128'(cyc), 128'(e.cyc));
            chk("cachehit2", 128'(CacheHit2), 128'(e.hit));
            chk("dataout2", 128'(DataOut2), 128'(e.data));
         end
      end
      if ((rd_mem2 || wr_mem2) && !stall2) begin
         if (mem2_q.size() == 0) unexp("mem2_op");
         else begin
            mem_e e;
            e = mem2_q.pop_front();
            chk("mem2_wr", 128'(wr_mem2), 128'(e.wr));
            chk("mem2_addr", 128'(Addr_mem2), 128'(e.addr));
         end
      end
      if (wr_cache2 && !cmp_ct2) begin
         if (fill2_q.size() == 0) unexp("fill2");
         else begin
            fill_e e;
            e = fill2_q.pop_front();
            chk("fill2_off", 128'(offset_cache2), 128'(e.off));
            chk("fill2_data", 128'(DataIn_ct2), 128'(e.data));
            chk("fill2_tag", 128'(tag_cache2), 128'(e.tag));
         end
      end
      if (err2) unexp("err2");
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
      Rd = r; Wr = w; Addr = a; DataIn = d;
      tick(1);
      Rd = 1'b0; Wr = 1'b0; Addr = 16'hFFFF; DataIn = 16'h0000;
   endtask

   task automatic zero_outs(input string n);
      chk(n, 128'({enable_ct, cmp_ct, wr_cache, valid_in_ct,
                   index_cache, offset_cache, tag_cache, DataIn_ct,
                   Addr_mem, DataIn_mem, wr_mem, rd_mem, DataOut,
                   Done, CacheHit, Stall_sys, err}), 128'(0));
   endtask

   task automatic zero_outs2(input string n);
      chk(n, 128'({enable_ct2, cmp_ct2, wr_cache2, valid_in_ct2,
                   index_cache2, offset_cache2, tag_cache2,
                   DataIn_ct2, Addr_mem2, DataIn_mem2, wr_mem2,
                   rd_mem2, DataOut2, Done2, CacheHit2, Stall_sys2,
                   err2}), 128'(0));
   endtask

   initial begin
      int t;
      rst = 1'b1; rst2 = 1'b1;
      Rd = 0; Wr = 0; Addr = 0; DataIn = 0;
      hit = 0; dirty = 0; valid = 0; stall = 0; tag_out = 0;
      cbase = 16'h0000;
      Rd2 = 0; Wr2 = 0; Addr2 = 0; DataIn2 = 0;
      hit2 = 0; dirty2 = 0; valid2 = 0; stall2 = 0; tag_out2 = 0;
      tick(3);
      rst = 1'b0; rst2 = 1'b0;
      tick(1);
      zero_outs("reset_outs");
      zero_outs2("reset_outs2");

      // read hit at 0x1234
      hit = 1; valid = 1; dirty = 0; cbase = 16'h1000;
      t = cyc;
      exp_done(t + 2, 16'h1004, 1'b1, 1'b1);
      issue(1, 0, 16'h1234, 16'h0);
      tick(4);

      // write hit at 0x0A06
      t = cyc;
      exp_cwr(t + 1, 3'd6, 16'h7777);
      exp_done(t + 2, 16'h0, 1'b0, 1'b1);
      issue(0, 1, 16'h0A06, 16'h7777);
      tick(4);

      // clean read miss at 0x4A08
      hit = 0; valid = 1; dirty = 0; cbase = 16'h2000;
      t = cyc;
      for (int i = 0; i < 4; i++) begin
         exp_mem(0, 16'h4A08 + 16'(2 * i), 16'h0);
         exp_fill(4'(2 * i), mdata(16'h4A08 + 16'(2 * i)), 5'h09);
      end
      exp_done(t + 9, 16'h2000, 1'b1, 1'b0);
      issue(1, 0, 16'h4A08, 16'h0);
      tick(12);

      // dirty write miss at 0x5A16, victim tag 0x15
      hit = 0; valid = 1; dirty = 1; tag_out = 5'h15;
      cbase = 16'h3000;
      t = cyc;
      for (int i = 0; i < 4; i++)
         exp_mem(1, 16'hAA10 + 16'(2 * i), 16'h3000 + 16'(2 * i));
      for (int i = 0; i < 4; i++) begin
         exp_mem(0, 16'h5A10 + 16'(2 * i), 16'h0);
         exp_fill(4'(2 * i), mdata(16'h5A10 + 16'(2 * i)), 5'h0B);
      end
      exp_cwr(t + 1, 3'd6, 16'h3C3C);
      exp_cwr(t + 12, 3'd6, 16'h3C3C);
      exp_done(t + 13, 16'h0, 1'b0, 1'b0);
      issue(0, 1, 16'h5A16, 16'h3C3C);
      tick(15);

      // clean read miss with 3 stall cycles on the second issue
      hit = 0; valid = 1; dirty = 0; tag_out = 0; cbase = 16'h2000;
      t = cyc;
      for (int i = 0; i < 4; i++) begin
         exp_mem(0, 16'h4A08 + 16'(2 * i), 16'h0);
         exp_fill(4'(2 * i), mdata(16'h4A08 + 16'(2 * i)), 5'h09);
      end
      exp_done(t + 12, 16'h2000, 1'b1, 1'b0);
      issue(1, 0, 16'h4A08, 16'h0);
      tick(2);
      stall = 1;
      tick(1);
      chk("stall_addr_hold", 128'(Addr_mem), 128'(16'h4A0A));
      tick(2);
      stall = 0;
      tick(10);

      // illegal requests
      t = cyc;
      err_q.push_back(t + 1);
      issue(1, 1, 16'h0100, 16'h0);
      tick(3);
      t = cyc;
      err_q.push_back(t + 1);
      issue(1, 0, 16'h0001, 16'h0);
      tick(3);

      // reset in the middle of a fill
      hit = 0; valid = 1; dirty = 0; cbase = 16'h2000;
      for (int i = 0; i < 3; i++)
         exp_mem(0, 16'h4A08 + 16'(2 * i), 16'h0);
      exp_fill(4'd0, mdata(16'h4A08), 5'h09);
      issue(1, 0, 16'h4A08, 16'h0);
      tick(3);
      rst = 1'b1;
      tick(1);
      zero_outs("rst_mid_fill_outs");
      rst = 1'b0;
      tick(3);
      hit = 1; valid = 1; cbase = 16'h1000;
      t = cyc;
      exp_done(t + 2, 16'h1004, 1'b1, 1'b1);
      issue(1, 0, 16'h1234, 16'h0);
      tick(4);

      // second geometry: reset mid-fill, then a clean miss
      for (int i = 0; i < 5; i++)
         mem2_q.push_back('{0, 16'h4A00 + 16'(2 * i), 16'h0});
      fill2_q.push_back('{4'd0, mdata(16'h4A00), 5'h04});
      Rd2 = 1; Addr2 = 16'h4A00;
      tick(1);
      Rd2 = 0; Addr2 = 16'hFFFF;
      tick(5);
      rst2 = 1'b1;
      tick(1);
      zero_outs2("rst2_mid_fill_outs");
      rst2 = 1'b0;
      tick(3);
      t = cyc;
      for (int i = 0; i < 8; i++) begin
         mem2_q.push_back('{0, 16'h4A00 + 16'(2 * i), 16'h0});
         fill2_q.push_back('{4'(2 * i),
                             mdata(16'h4A00 + 16'(2 * i)), 5'h04});
      end
      done2_q.push_back('{t + 15, 16'h00C2, 1'b1, 1'b0});
      Rd2 = 1; Addr2 = 16'h4A00;
      tick(1);
      Rd2 = 0; Addr2 = 16'hFFFF;
      tick(20);

      // anything still expected never appeared
      while (done_q.size() > 0) begin
         void'(done_q.pop_front()); unexp("missing_done");
      end
      while (mem_q.size() > 0) begin
         void'(mem_q.pop_front()); unexp("missing_mem");
      end
      while (fill_q.size() > 0) begin
         void'(fill_q.pop_front()); unexp("missing_fill");
      end
      while (cwr_q.size() > 0) begin
         void'(cwr_q.pop_front()); unexp("missing_cwr");
      end
      while (err_q.size() > 0) begin
         void'(err_q.pop_front()); unexp("missing_err");
      end
      while (done2_q.size() > 0) begin
         void'(done2_q.pop_front()); unexp("missing_done2");
      end
      while (mem2_q.size() > 0) begin
         void'(mem2_q.pop_front()); unexp("missing_mem2");
      end
      while (fill2_q.size() > 0) begin
         void'(fill2_q.pop_front()); unexp("missing_fill2");
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cache_ctrl_param.md
# cache_ctrl_param

Parametrised direct-mapped cache controller FSM. It sits between the processor memory port and the cache data/tag array plus the banked main memory. It generalises the 16-bit, 4-word-line controller to configurable address/data width, index width, line length and memory read latency. It also adds memory-stall retry, request latching, a registered read-data return and error detection.

## Interface
- ADDR_W, 16, address width (byte address)
- DATA_W, 16, word width; BOFF_W = $clog2(DATA_W/8)
- INDEX_W, 8, cache index bits
- WORDS, 4, words per line (power of 2); WOFF_W = $clog2(WORDS); TAG_W = ADDR_W-INDEX_W-WOFF_W-BOFF_W
- MEM_LAT, 2, cycles from accepted memory read to DataOut_mem valid (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high (already decided)
- Addr, DataIn  in  ADDR_W, DATA_W  request address / write data; layout {tag, index, word, byte}
- Rd, Wr  in  1  request strobes, sampled only in IDLE
- hit, dirty, valid  in  1  cache compare results
- tag_out  in  TAG_W  stored tag of indexed line
- DataOut_cache  in  DATA_W  cache read data (combinational)
- DataOut_mem  in  DATA_W  memory read return
- stall  in  1  memory busy; a request issued while high is not accepted
- enable_ct, cmp_ct, wr_cache, valid_in_ct  out  1  cache controls
- index_cache  out  INDEX_W; offset_cache  out  WOFF_W+BOFF_W; tag_cache  out  TAG_W
- DataIn_ct  out  DATA_W  cache write data
- Addr_mem  out  ADDR_W; DataIn_mem  out  DATA_W; wr_mem, rd_mem  out  1
- DataOut  out  DATA_W  registered read data, valid with Done on reads
- Done, CacheHit, Stall_sys, err  out  1

## Operation
- States: IDLE, COMPARE, WB, FILL, RETRY, DONE.
- IDLE: Stall_sys=0.
  - Rd^Wr: latch Addr, DataIn and op, then go to COMPARE.
  - Rd&Wr, or Addr byte bits ≠0: err=1 for one cycle, no access, stay IDLE.
- COMPARE: enable_ct=cmp_ct=1, wr_cache=op_wr, fields from latched address, DataIn_ct=latched data.
  - hit&valid: DONE with CacheHit latched 1; read captures DataOut_cache into DataOut.
  - else valid&dirty: WB.
  - else: FILL.
- WB: counter i=0..WORDS-1, cache read of word i (enable_ct=1, cmp_ct=0).
  - wr_mem=1, Addr_mem={tag_out, index, i, 0}, DataIn_mem=DataOut_cache.
  - i advances only when stall=0. Leave for FILL after the write of word WORDS-1 is accepted.
- FILL has two independent counters:
  - Issue counter: rd_mem=1, Addr_mem={tag, index, i, 0} while i<WORDS; advances when stall=0.
  - Fill tracker: each accepted read enters a MEM_LAT-deep pipe of {valid, word}. On exit: wr_cache=1, valid_in_ct=1, cmp_ct=0, enable_ct=1, tag_cache=req tag, offset={word,0}, DataIn_ct=DataOut_mem.
  - Go to RETRY when the WORDS-th return is written.
- RETRY: same as COMPARE. Write op stores data; read op captures DataOut. Go to DONE with CacheHit latched 0. The hit input is ignored.
- DONE: Done=1 for one cycle, CacheHit per latch, then IDLE. Stall_sys=1 in all states except IDLE.
- Unused outputs drive 0 (no X). Illegal state encoding: err=1 and return to IDLE.

## Timing
- Reset: state IDLE, counters and tracker pipe cleared, every output 0 except Stall_sys=0. rst mid-operation aborts immediately; in-flight returns are discarded.
- Read/write hit: accept at T, COMPARE T+1, Done at T+2.
- Clean miss, no stall: issues T+2..T+1+WORDS; last cache write at T+1+WORDS+MEM_LAT; RETRY next cycle; Done at T+3+WORDS+MEM_LAT. Defaults give T+9.
- Dirty miss: add WORDS cycles, plus one cycle per stalled write.
- A stall cycle during FILL delays issue only. Returns already in the pipe still write.
- Rd/Wr/Addr changes after acceptance are ignored.

## Structure
- Package cache_ctrl_pkg: state enum, width helper functions (BOFF_W, WOFF_W, TAG_W), field-extract functions.
- Sub-module cache_fill_tracker: MEM_LAT-deep shift pipe of {valid, word}, with push on accepted read and a completion count.

## Test plan
- Read hit at Addr=0x1234: hit=valid=1 in COMPARE -> Done&CacheHit at T+2, DataOut=DataOut_cache, no rd_mem/wr_mem.
- Clean read miss at Addr=0x4A08 (defaults) -> rd_mem at 0x4A08,0x4A0A,0x4A0C,0x4A0E; 4 cache writes with valid_in_ct=1; Done at T+9, CacheHit=0.
- Dirty write miss, tag_out=0x15 -> 4 wr_mem to old-tag line before any rd_mem; RETRY asserts wr_cache with DataIn; Done at T+13.
- stall high 3 cycles during second fill issue -> Addr_mem held, no duplicate or skipped word, Done delayed exactly 3 cycles.
- Rd=Wr=1, or Addr=0x0001 -> err pulse of one cycle, no cache/memory activity.
- rst asserted mid-FILL -> next cycle IDLE, all outputs 0, Stall_sys=0; a later request behaves normally. Repeat with MEM_LAT=4, WORDS=8.
